// File: rtl/tb_tcdm_initiator_pkg.sv
// Shared types, mode bit positions and the pattern LFSR for the TCDM initiator.
package tb_tcdm_initiator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam int unsigned MODE_WR_BIT = 0;
    localparam int unsigned MODE_RD_BIT = 1;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [3:0]  BE_ALL    = 4'hF;

    // One step of the 32-bit Galois LFSR.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    // A zero seed would lock the LFSR, so it is replaced by 1.
    function automatic logic [31:0] lfsr_seed(input logic [31:0] s);
        return (s == 32'd0) ? 32'd1 : s;
    endfunction

endpackage

// File: rtl/hwpe_stream_intf_tcdm.sv
// Single-port TCDM request/response bundle.
interface hwpe_stream_intf_tcdm;
    logic        req;
    logic        gnt;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] r_data;
    logic        r_valid;

    modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
    modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/tb_tcdm_initiator_exp_fifo.sv
// Expected-response FIFO; push and pop may happen in the same cycle.
module tb_tcdm_initiator_exp_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [31:0] wdata,
    input  logic        pop,
    output logic [31:0] head_c
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= (wptr == LAST) ? '0 : wptr + PTR_W'(1);
            if (pop)  rptr <= (rptr == LAST) ? '0 : rptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    assign head_c = mem[rptr];

endmodule

// File: rtl/tb_tcdm_initiator.sv
// Self-checking TCDM master: write/read bursts with bounded outstanding requests.
// Define TCDM_INIT_LFSR_EN to draw the data pattern from a Galois LFSR instead of address^seed.
module tb_tcdm_initiator
    import tb_tcdm_initiator_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [1:0]           mode_i,
    input  logic [31:0]          base_addr_i,
    input  logic [CNT_W-1:0]     n_words_i,
    input  logic [31:0]          seed_i,
    hwpe_stream_intf_tcdm.master tcdm,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_W-1:0]     err_cnt_o,
    output logic [CNT_W-1:0]     rsp_cnt_o
);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [CNT_W-1:0] idx);
        return base + (32'(idx) << 2);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    state_e           state;
    logic             rd_en_q;
    logic [31:0]      base_q;
    logic [CNT_W-1:0] n_q;
    logic [31:0]      seed_q;
    logic [CNT_W-1:0] idx;
    logic [OUT_W-1:0] out_cnt;
    logic             req_q;
    logic [31:0]      add_q;
    logic             wen_q;
    logic [3:0]       be_q;
    logic [31:0]      data_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] err_q;
    logic [CNT_W-1:0] rsp_q;

    logic             accept;
    logic             issue;
    logic             pop;
    logic             spurious;
    logic             mismatch;
    logic             last_issue;
    logic             to_read;
    logic             room_nxt;
    logic [CNT_W-1:0] idx_inc;
    logic [OUT_W-1:0] out_nxt;
    logic [31:0]      exp_head;
    logic [31:0]      start_base;
    logic [31:0]      pat_start;
    logic [31:0]      pat_first;
    logic [31:0]      pat_step;

    assign accept     = (state == ST_IDLE) && start_i;
    assign issue      = req_q && tcdm.gnt;
    assign pop        = tcdm.r_valid && (out_cnt != '0);
    assign spurious   = tcdm.r_valid && (out_cnt == '0);
    assign mismatch   = pop && (exp_head != tcdm.r_data);
    assign idx_inc    = idx + CNT_W'(issue);
    assign last_issue = issue && (idx_inc == n_q);
    assign to_read    = (state == ST_WRITE) && last_issue && rd_en_q;
    assign out_nxt    = out_cnt + OUT_W'(issue) - OUT_W'(pop);
    assign room_nxt   = out_nxt < OUT_W'(MAX_OUTSTANDING);
    assign start_base = {base_addr_i[31:2], 2'b00};

`ifdef TCDM_INIT_LFSR_EN
    logic [31:0] lfsr_q;

    assign pat_start = lfsr_seed(seed_i);
    assign pat_first = lfsr_seed(seed_q);
    assign pat_step  = issue ? lfsr_next(lfsr_q) : lfsr_q;

    // lfsr_q always holds the pattern for the current index.
    always_ff @(posedge clk_i) begin
        if (!rst_ni)      lfsr_q <= '0;
        else if (accept)  lfsr_q <= pat_start;
        else if (to_read) lfsr_q <= pat_first;
        else if (issue)   lfsr_q <= lfsr_next(lfsr_q);
    end
`else
    assign pat_start = start_base ^ seed_i;
    assign pat_first = base_q ^ seed_q;
    assign pat_step  = word_addr(base_q, idx_inc) ^ seed_q;
`endif

    tb_tcdm_initiator_exp_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) i_exp_fifo (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .push   (issue),
        .wdata  (data_q),
        .pop    (pop),
        .head_c (exp_head)
    );

    // Response bookkeeping; counters restart on every accepted start.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_cnt <= '0;
            err_q   <= '0;
            rsp_q   <= '0;
        end else begin
            out_cnt <= out_nxt;
            if (accept) begin
                err_q <= '0;
                rsp_q <= '0;
            end else if (tcdm.r_valid) begin
                rsp_q <= sat_inc(rsp_q);
                if (spurious || mismatch) err_q <= sat_inc(err_q);
            end
        end
    end

    // Burst FSM; request outputs are precomputed for the next cycle so they hold during stalls.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state   <= ST_IDLE;
            rd_en_q <= 1'b0;
            base_q  <= '0;
            n_q     <= '0;
            seed_q  <= '0;
            idx     <= '0;
            req_q   <= 1'b0;
            add_q   <= '0;
            wen_q   <= 1'b1;
            be_q    <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        rd_en_q <= mode_i[MODE_RD_BIT];
                        base_q  <= start_base;
                        n_q     <= n_words_i;
                        seed_q  <= seed_i;
                        idx     <= '0;
                        add_q   <= start_base;
                        data_q  <= pat_start;
                        be_q    <= BE_ALL;
                        busy_q  <= 1'b1;
                        if ((n_words_i == '0) || (mode_i == 2'b00)) begin
                            state <= ST_DRAIN;
                            req_q <= 1'b0;
                        end else if (mode_i[MODE_WR_BIT]) begin
                            state <= ST_WRITE;
                            wen_q <= 1'b0;
                            req_q <= 1'b1;
                        end else begin
                            state <= ST_READ;
                            wen_q <= 1'b1;
                            req_q <= 1'b1;
                        end
                    end
                end
                ST_WRITE, ST_READ: begin
                    if (to_read) begin
                        state  <= ST_READ;
                        idx    <= '0;
                        wen_q  <= 1'b1;
                        add_q  <= base_q;
                        data_q <= pat_first;
                        req_q  <= room_nxt;
                    end else if (last_issue) begin
                        state <= ST_DRAIN;
                        idx   <= idx_inc;
                        req_q <= 1'b0;
                    end else begin
                        idx    <= idx_inc;
                        add_q  <= word_addr(base_q, idx_inc);
                        data_q <= pat_step;
                        req_q  <= room_nxt;
                    end
                end
                ST_DRAIN: begin
                    if (out_nxt == '0) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign tcdm.req  = req_q;
    assign tcdm.add  = add_q;
    assign tcdm.wen  = wen_q;
    assign tcdm.be   = be_q;
    assign tcdm.data = data_q;

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_cnt_o = err_q;
    assign rsp_cnt_o = rsp_q;

endmodule

// File: tb/tb_tb_tcdm_initiator.sv
// Bench for tb_tcdm_initiator: TCDM slave model with configurable stall, latency and corruption.
module tb_tb_tcdm_initiator;
    localparam int MAX_OUT = 2;
    localparam int CNT_W   = 16;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic             start_i;
    logic [1:0]       mode_i;
    logic [31:0]      base_addr_i;
    logic [CNT_W-1:0] n_words_i;
    logic [31:0]      seed_i;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] err_cnt_o;
    logic [CNT_W-1:0] rsp_cnt_o;

    hwpe_stream_intf_tcdm tcdm_if ();

    tb_tcdm_initiator #(
        .MAX_OUTSTANDING (MAX_OUT),
        .CNT_W           (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .mode_i      (mode_i),
        .base_addr_i (base_addr_i),
        .n_words_i   (n_words_i),
        .seed_i      (seed_i),
        .tcdm        (tcdm_if),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_cnt_o   (err_cnt_o),
        .rsp_cnt_o   (rsp_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // slave configuration (written by the stimulus process only)
    int lat        = 1;
    bit stall_en   = 1'b0;
    int corrupt_at = -1;
    int inj_req    = 0;

    // slave state and statistics (written by the slave process only)
    logic [31:0] mem [1024];
    int          q_due [$];
    logic [31:0] q_dat [$];
    logic [31:0] rsp_log [$];
    int          grant_cyc [$];
    logic [31:0] d;
    logic [31:0] prev_add, prev_data;
    logic [3:0]  prev_be;
    logic        prev_wen;
    bit last_issue, prev_req, prev_gnt, prev_qrv;
    int cyc = 0, out_b = 0, max_out = 0, grants = 0, reads = 0;
    int stab_err = 0, ovf_err = 0, be_err = 0;
    int done_cnt = 0, done_cyc = 0, last_rv_cyc = 0, inj_ack = 0;

    // Slave: decides gnt and drives responses at the falling edge, so the DUT sees them stable.
    always @(negedge clk) begin
        if (!rst_ni) begin
            q_due.delete();
            q_dat.delete();
            tcdm_if.gnt     = 1'b0;
            tcdm_if.r_valid = 1'b0;
            tcdm_if.r_data  = '0;
            last_issue = 1'b0;
            prev_req   = 1'b0;
            prev_gnt   = 1'b0;
            prev_qrv   = 1'b0;
            out_b      = 0;
        end else begin
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (last_issue) begin
                grants++;
                grant_cyc.push_back(cyc - 1);
                if (prev_be != 4'hF) be_err++;
                if (!prev_wen) begin
                    mem[prev_add[11:2]] = prev_data;
                    d = prev_data;
                end else begin
                    reads++;
                    d = mem[prev_add[11:2]];
                    if (reads == corrupt_at) d[0] = ~d[0];
                end
                q_due.push_back(cyc - 1 + lat);
                q_dat.push_back(d);
                out_b++;
            end
            if (prev_qrv) out_b--;
            if (prev_req && !prev_gnt) begin
                if (!(tcdm_if.req === 1'b1 && tcdm_if.add === prev_add &&
                      tcdm_if.wen === prev_wen && tcdm_if.data === prev_data))
                    stab_err++;
            end
            prev_qrv = 1'b0;
            if (q_due.size() > 0 && q_due[0] <= cyc) begin
                tcdm_if.r_valid = 1'b1;
                tcdm_if.r_data  = q_dat.pop_front();
                void'(q_due.pop_front());
                rsp_log.push_back(tcdm_if.r_data);
                last_rv_cyc = cyc;
                prev_qrv    = 1'b1;
            end else if (inj_req != inj_ack) begin
                tcdm_if.r_valid = 1'b1;
                tcdm_if.r_data  = 32'hDEAD_BEEF;
                inj_ack = inj_req;
            end else begin
                tcdm_if.r_valid = 1'b0;
            end
            if (tcdm_if.req && out_b >= MAX_OUT) ovf_err++;
            if (out_b > max_out) max_out = out_b;
            tcdm_if.gnt = tcdm_if.req && (!stall_en || ($urandom_range(0, 1) == 1));
            prev_req   = tcdm_if.req;
            prev_gnt   = tcdm_if.gnt;
            prev_add   = tcdm_if.add;
            prev_wen   = tcdm_if.wen;
            prev_be    = tcdm_if.be;
            prev_data  = tcdm_if.data;
            last_issue = tcdm_if.req && tcdm_if.gnt;
        end
        cyc++;
    end

    task automatic pulse_start(input logic [1:0] m, input logic [31:0] b, input int n, input logic [31:0] s);
        mode_i      = m;
        base_addr_i = b;
        n_words_i   = CNT_W'(n);
        seed_i      = s;
        start_i     = 1'b1;
        @(negedge clk);
        start_i     = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        checks++; if (tcdm_if.req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b exp 0", tcdm_if.req); end
        checks++; if (tcdm_if.add !== 32'h0) begin errors++; $display("FAIL reset_add got %0h exp 0", tcdm_if.add); end
        checks++; if (tcdm_if.wen !== 1'b1) begin errors++; $display("FAIL reset_wen got %0b exp 1", tcdm_if.wen); end
        checks++; if (tcdm_if.be !== 4'h0) begin errors++; $display("FAIL reset_be got %0h exp 0", tcdm_if.be); end
        checks++; if (tcdm_if.data !== 32'h0) begin errors++; $display("FAIL reset_data got %0h exp 0", tcdm_if.data); end
        checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %0b%0b exp 00", busy_o, done_o); end
        checks++; if (err_cnt_o !== '0 || rsp_cnt_o !== '0) begin errors++; $display("FAIL reset_cnts got %0d/%0d exp 0/0", err_cnt_o, rsp_cnt_o); end
    endtask

    task automatic test_write_read();
        int g0 = grants, r0 = rsp_log.size(), d0 = done_cnt, gq0 = grant_cyc.size();
        bit ok;
        logic [31:0] exp;
        lat = 1; stall_en = 1'b0;
        pulse_start(2'b11, 32'h100, 8, 32'h0);
        checks++; if (tcdm_if.req !== 1'b1 || tcdm_if.wen !== 1'b0 || tcdm_if.add !== 32'h100 || tcdm_if.data !== 32'h100) begin
            errors++; $display("FAIL wr_first_req got req=%0b wen=%0b add=%0h data=%0h exp 1 0 100 100", tcdm_if.req, tcdm_if.wen, tcdm_if.add, tcdm_if.data);
        end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL wr_busy got %0b exp 1", busy_o); end
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wr_done_timeout got 0 exp 1"); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL wr_busy_at_done got %0b exp 0", busy_o); end
        repeat (2) @(negedge clk);
        checks++; if (grants - g0 != 16) begin errors++; $display("FAIL wr_grants got %0d exp 16", grants - g0); end
        if (grant_cyc.size() >= gq0 + 16) begin
            checks++; if (grant_cyc[gq0 + 15] - grant_cyc[gq0] != 15) begin
                errors++; $display("FAIL wr_grant_span got %0d exp 15", grant_cyc[gq0 + 15] - grant_cyc[gq0]);
            end
        end
        checks++; if (rsp_log.size() - r0 != 16) begin errors++; $display("FAIL wr_rsp_log got %0d exp 16", rsp_log.size() - r0); end
        for (int i = 0; i < 16 && r0 + i < rsp_log.size(); i++) begin
            exp = 32'h100 + 32'(4 * (i % 8));
            checks++; if (rsp_log[r0 + i] !== exp) begin errors++; $display("FAIL wr_rdata[%0d] got %0h exp %0h", i, rsp_log[r0 + i], exp); end
        end
        checks++; if (err_cnt_o !== 16'd0) begin errors++; $display("FAIL wr_err got %0d exp 0", err_cnt_o); end
        checks++; if (rsp_cnt_o !== 16'd16) begin errors++; $display("FAIL wr_rsp got %0d exp 16", rsp_cnt_o); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL wr_done_pulses got %0d exp 1", done_cnt - d0); end
        checks++; if (done_cyc - last_rv_cyc != 1) begin errors++; $display("FAIL wr_done_latency got %0d exp 1", done_cyc - last_rv_cyc); end
        checks++; if (be_err != 0) begin errors++; $display("FAIL wr_be got %0d bad exp 0", be_err); end
    endtask

    task automatic test_stall();
        int g0 = grants, r0 = rsp_log.size(), s0 = stab_err, o0 = ovf_err, bad = 0;
        bit ok;
        logic [31:0] exp;
        lat = 2; stall_en = 1'b1;
        pulse_start(2'b11, 32'h400, 64, 32'hA5A5_5A5A);
        repeat (10) @(negedge clk);
        pulse_start(2'b01, 32'h0, 2, 32'h0);
        wait_done(2000, ok);
        repeat (2) @(negedge clk);
        stall_en = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL stall_done_timeout got 0 exp 1"); end
        checks++; if (stab_err != s0) begin errors++; $display("FAIL stall_stability got %0d exp 0", stab_err - s0); end
        checks++; if (ovf_err != o0) begin errors++; $display("FAIL stall_outstanding got %0d exp 0", ovf_err - o0); end
        checks++; if (grants - g0 != 128) begin errors++; $display("FAIL stall_grants got %0d exp 128", grants - g0); end
        checks++; if (err_cnt_o !== 16'd0) begin errors++; $display("FAIL stall_err got %0d exp 0", err_cnt_o); end
        checks++; if (rsp_cnt_o !== 16'd128) begin errors++; $display("FAIL stall_rsp got %0d exp 128", rsp_cnt_o); end
        for (int i = 0; i < 128 && r0 + i < rsp_log.size(); i++) begin
            exp = (32'h400 + 32'(4 * (i % 64))) ^ 32'hA5A5_5A5A;
            if (rsp_log[r0 + i] !== exp) bad++;
        end
        checks++; if (bad != 0 || rsp_log.size() - r0 != 128) begin
            errors++; $display("FAIL stall_rdata got %0d bad of %0d exp 0 of 128", bad, rsp_log.size() - r0);
        end
    endtask

    task automatic test_corrupt();
        bit ok;
        lat = 1;
        corrupt_at = reads + 3;
        pulse_start(2'b11, 32'h800, 4, 32'h1234_5678);
        wait_done(200, ok);
        repeat (2) @(negedge clk);
        corrupt_at = -1;
        checks++; if (!ok) begin errors++; $display("FAIL corrupt_done_timeout got 0 exp 1"); end
        checks++; if (err_cnt_o !== 16'd1) begin errors++; $display("FAIL corrupt_err got %0d exp 1", err_cnt_o); end
        checks++; if (rsp_cnt_o !== 16'd8) begin errors++; $display("FAIL corrupt_rsp got %0d exp 8", rsp_cnt_o); end
    endtask

    task automatic test_zero_words();
        int g0 = grants;
        pulse_start(2'b11, 32'h100, 0, 32'h5);
        checks++; if (tcdm_if.req !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++; $display("FAIL zero_c1 got req=%0b done=%0b busy=%0b exp 0 0 1", tcdm_if.req, done_o, busy_o);
        end
        @(negedge clk);
        checks++; if (done_o !== 1'b1 || busy_o !== 1'b0 || tcdm_if.req !== 1'b0) begin
            errors++; $display("FAIL zero_c2 got done=%0b busy=%0b req=%0b exp 1 0 0", done_o, busy_o, tcdm_if.req);
        end
        @(negedge clk);
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL zero_c3 got done=%0b exp 0", done_o); end
        @(negedge clk);
        checks++; if (grants != g0) begin errors++; $display("FAIL zero_grants got %0d exp 0", grants - g0); end
        checks++; if (err_cnt_o !== 16'd0 || rsp_cnt_o !== 16'd0) begin errors++; $display("FAIL zero_cnts got %0d/%0d exp 0/0", err_cnt_o, rsp_cnt_o); end
    endtask

    task automatic test_latency();
        int o0 = ovf_err;
        bit ok;
        lat = 4;
        pulse_start(2'b01, 32'hC00, 8, 32'h0);
        wait_done(400, ok);
        repeat (2) @(negedge clk);
        lat = 1;
        checks++; if (!ok) begin errors++; $display("FAIL lat_done_timeout got 0 exp 1"); end
        checks++; if (ovf_err != o0) begin errors++; $display("FAIL lat_req_at_limit got %0d exp 0", ovf_err - o0); end
        checks++; if (max_out != 2) begin errors++; $display("FAIL lat_max_outstanding got %0d exp 2", max_out); end
        checks++; if (err_cnt_o !== 16'd0 || rsp_cnt_o !== 16'd8) begin errors++; $display("FAIL lat_cnts got %0d/%0d exp 0/8", err_cnt_o, rsp_cnt_o); end
    endtask

    task automatic test_reset_mid();
        lat = 1;
        pulse_start(2'b11, 32'h100, 32, 32'h0);
        repeat (4) @(negedge clk);
        checks++; if (tcdm_if.req !== 1'b1 || tcdm_if.wen !== 1'b0) begin
            errors++; $display("FAIL rstmid_in_write got req=%0b wen=%0b exp 1 0", tcdm_if.req, tcdm_if.wen);
        end
        rst_ni = 1'b0;
        @(negedge clk);
        checks++; if (tcdm_if.req !== 1'b0 || tcdm_if.add !== 32'h0 || tcdm_if.wen !== 1'b1 || tcdm_if.be !== 4'h0 || tcdm_if.data !== 32'h0) begin
            errors++; $display("FAIL rstmid_tcdm got req=%0b add=%0h wen=%0b be=%0h data=%0h exp 0 0 1 0 0",
                               tcdm_if.req, tcdm_if.add, tcdm_if.wen, tcdm_if.be, tcdm_if.data);
        end
        checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || err_cnt_o !== '0 || rsp_cnt_o !== '0) begin
            errors++; $display("FAIL rstmid_outs got busy=%0b done=%0b err=%0d rsp=%0d exp 0 0 0 0", busy_o, done_o, err_cnt_o, rsp_cnt_o);
        end
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);
        inj_req++;
        repeat (3) @(negedge clk);
        checks++; if (err_cnt_o !== 16'd1) begin errors++; $display("FAIL spurious_err got %0d exp 1", err_cnt_o); end
        checks++; if (rsp_cnt_o !== 16'd1) begin errors++; $display("FAIL spurious_rsp got %0d exp 1", rsp_cnt_o); end
        checks++; if (busy_o !== 1'b0 || tcdm_if.req !== 1'b0) begin errors++; $display("FAIL spurious_idle got busy=%0b req=%0b exp 0 0", busy_o, tcdm_if.req); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        mode_i      = 2'b00;
        base_addr_i = '0;
        n_words_i   = '0;
        seed_i      = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);
        test_write_read();
        test_stall();
        test_corrupt();
        test_zero_words();
        test_latency();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
